// File: rtl/vga_theme_sel.sv
// VGA colour-theme selector: debounced next/prev buttons plus a direct-select
// strobe update a pending target theme, which is committed to the pixel
// pipeline only on a frame boundary so a frame never mixes two themes.

// Per-button path: 2-flop synchroniser, debounce, rising-edge press event.
module vga_theme_btn #(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int CNT_W        = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1, sync2;
  logic             stable, stable_q;
  logic [CNT_W-1:0] cnt;

  // Synchronise, then accept a new level only after it has differed from the
  // accepted level for DEBOUNCE_CYC consecutive cycles; any return clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_q <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_q <= stable;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Press only; releases produce nothing.
  assign press = stable & ~stable_q;
endmodule

module vga_theme_sel #(
  parameter int N_THEMES     = 3,
  parameter int IDX_W        = 4,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int CNT_W        = 20,
  parameter int RESET_THEME  = 0,
  parameter int FRAME_SYNC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_next,
  input  logic             btn_prev,
  input  logic             sel_valid,
  input  logic [IDX_W-1:0] sel_idx,
  input  logic             lock,
  input  logic             frame_start,
  output logic [IDX_W-1:0] theme,
  output logic [IDX_W-1:0] theme_tgt,
  output logic             theme_pending,
  output logic             theme_chg
);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(N_THEMES - 1);
  localparam logic [IDX_W-1:0] RST_IDX = IDX_W'(RESET_THEME);
  localparam logic [IDX_W:0]   N_EXT   = (IDX_W+1)'(N_THEMES);

  // [0] = next, [1] = prev
  logic [1:0]       press;
  logic [IDX_W-1:0] tgt_nxt;
  logic             sel_ok;
  logic             commit;

  vga_theme_btn #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .CNT_W       (CNT_W)
  ) u_btn [1:0] (
    .clk  (clk),
    .rst  (rst),
    .raw  ({btn_prev, btn_next}),
    .press(press)
  );

  // Widened compare so N_THEMES == 2**IDX_W still works.
  assign sel_ok = sel_valid && ({1'b0, sel_idx} < N_EXT);

  // Request resolution: valid direct select wins and drops button events;
  // simultaneous next+prev cancel; lock drops everything.
  always_comb begin
    tgt_nxt = theme_tgt;
    if (!lock) begin
      if (sel_ok)
        tgt_nxt = sel_idx;
      else if (press[0] && !press[1])
        tgt_nxt = (theme_tgt == LAST) ? '0 : theme_tgt + 1'b1;
      else if (press[1] && !press[0])
        tgt_nxt = (theme_tgt == '0) ? LAST : theme_tgt - 1'b1;
    end
  end

  // Commit samples the pre-request target; lock does not gate it.
  assign commit = ((FRAME_SYNC == 0) || frame_start) && (theme_tgt != theme);

  // Target / committed theme registers and the change pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      theme_tgt <= RST_IDX;
      theme     <= RST_IDX;
      theme_chg <= 1'b0;
    end else begin
      theme_tgt <= tgt_nxt;
      theme_chg <= commit;
      if (commit) theme <= theme_tgt;
    end
  end

  assign theme_pending = (theme_tgt != theme);
endmodule

// File: tb/tb_vga_theme_sel.sv
// Bench for vga_theme_sel (N_THEMES=3, DEBOUNCE_CYC=4, FRAME_SYNC=1).
module tb_vga_theme_sel;
  localparam int NT = 3;

  logic       clk = 1'b0;
  logic       rst, btn_next, btn_prev, sel_valid, lock, frame_start;
  logic [3:0] sel_idx;
  logic [3:0] theme, theme_tgt;
  logic       theme_pending, theme_chg;

  int tests = 0;
  int fails = 0;

  // reference model state
  int m_tgt, m_theme, m_chg;
  int cyc, nxt_due, prv_due;
  // bounce-window bookkeeping
  int         changes;
  logic [3:0] last_tgt;

  vga_theme_sel #(
    .N_THEMES(3), .IDX_W(4), .DEBOUNCE_CYC(4), .CNT_W(3),
    .RESET_THEME(0), .FRAME_SYNC(1)
  ) dut (
    .clk(clk), .rst(rst), .btn_next(btn_next), .btn_prev(btn_prev),
    .sel_valid(sel_valid), .sel_idx(sel_idx), .lock(lock),
    .frame_start(frame_start), .theme(theme), .theme_tgt(theme_tgt),
    .theme_pending(theme_pending), .theme_chg(theme_chg)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time exceeded, expected finish before 2000000");
    $fatal(1, "timeout");
  end

  // Advance n clock edges and land 1 time unit after the last one.
  task automatic waitn(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input bit n, input bit p);
    btn_next = n; btn_prev = p;
    waitn(10);
    btn_next = 0; btn_prev = 0;
    waitn(10);
  endtask

  task automatic pulse_frame();
    frame_start = 1;
    waitn(1);
    frame_start = 0;
  endtask

  task automatic sel(input int idx);
    sel_valid = 1; sel_idx = 4'(idx);
    waitn(1);
    sel_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    waitn(2);
    rst = 0;
  endtask

  task automatic count_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      waitn(1);
      if (theme_tgt !== last_tgt) begin changes++; last_tgt = theme_tgt; end
    end
  endtask

  task automatic test_reset();
    rst = 1;
    waitn(2);
    tests++; if (theme !== 4'd0) begin fails++; $display("FAIL reset_theme: got %0d expected 0", theme); end
    tests++; if (theme_tgt !== 4'd0) begin fails++; $display("FAIL reset_tgt: got %0d expected 0", theme_tgt); end
    tests++; if (theme_chg !== 1'b0) begin fails++; $display("FAIL reset_chg: got %0b expected 0", theme_chg); end
    tests++; if (theme_pending !== 1'b0) begin fails++; $display("FAIL reset_pending: got %0b expected 0", theme_pending); end
    rst = 0;
  endtask

  task automatic test_next_commit();
    btn_next = 1;
    waitn(6);
    tests++; if (theme_tgt !== 4'd0) begin fails++; $display("FAIL latency_early: tgt got %0d expected 0", theme_tgt); end
    waitn(1);
    tests++; if (theme_tgt !== 4'd1) begin fails++; $display("FAIL latency_7: tgt got %0d expected 1", theme_tgt); end
    tests++; if (theme_pending !== 1'b1) begin fails++; $display("FAIL pending_set: got %0b expected 1", theme_pending); end
    tests++; if (theme !== 4'd0) begin fails++; $display("FAIL theme_held: got %0d expected 0", theme); end
    waitn(3);
    btn_next = 0;
    waitn(10);
    pulse_frame();
    tests++; if (theme !== 4'd1) begin fails++; $display("FAIL commit_theme: got %0d expected 1", theme); end
    tests++; if (theme_chg !== 1'b1) begin fails++; $display("FAIL commit_chg: got %0b expected 1", theme_chg); end
    waitn(1);
    tests++; if (theme_chg !== 1'b0) begin fails++; $display("FAIL chg_one_cycle: got %0b expected 0", theme_chg); end
  endtask

  task automatic test_accumulate();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      press(1, 0);
      tests++;
      if (theme_tgt !== 4'((i + 1) % NT)) begin
        fails++; $display("FAIL accum_step%0d: tgt got %0d expected %0d", i, theme_tgt, (i + 1) % NT);
      end
    end
    tests++; if (theme_pending !== 1'b0) begin fails++; $display("FAIL accum_pending: got %0b expected 0", theme_pending); end
    pulse_frame();
    tests++; if (theme_chg !== 1'b0) begin fails++; $display("FAIL accum_no_chg: got %0b expected 0", theme_chg); end
    press(0, 1);
    tests++; if (theme_tgt !== 4'd2) begin fails++; $display("FAIL prev_wrap: tgt got %0d expected 2", theme_tgt); end
    pulse_frame();
    tests++; if (theme !== 4'd2) begin fails++; $display("FAIL prev_commit: theme got %0d expected 2", theme); end
    tests++; if (theme_chg !== 1'b1) begin fails++; $display("FAIL prev_chg: got %0b expected 1", theme_chg); end
  endtask

  task automatic test_bounce();
    int t, h, l;
    changes = 0; last_tgt = theme_tgt; t = 0;
    while (t < 20) begin
      h = $urandom_range(1, 3); l = $urandom_range(1, 3);
      btn_next = 1; count_cycles(h);
      btn_next = 0; count_cycles(l);
      t += h + l;
    end
    btn_next = 1; count_cycles(10);
    btn_next = 0; count_cycles(10);
    tests++; if (changes !== 1) begin fails++; $display("FAIL bounce_events: got %0d expected 1", changes); end
    tests++; if (theme_tgt !== 4'd0) begin fails++; $display("FAIL bounce_tgt: got %0d expected 0", theme_tgt); end
    press(1, 1);
    tests++; if (theme_tgt !== 4'd0) begin fails++; $display("FAIL both_cancel: tgt got %0d expected 0", theme_tgt); end
  endtask

  task automatic test_sel();
    sel(2);
    tests++; if (theme_tgt !== 4'd2) begin fails++; $display("FAIL sel_in_range: tgt got %0d expected 2", theme_tgt); end
    sel(0);
    tests++; if (theme_tgt !== 4'd0) begin fails++; $display("FAIL sel_zero: tgt got %0d expected 0", theme_tgt); end
    sel(2);
    sel(5);
    tests++; if (theme_tgt !== 4'd2) begin fails++; $display("FAIL sel_out_of_range: tgt got %0d expected 2", theme_tgt); end
    sel(3);
    tests++; if (theme_tgt !== 4'd2) begin fails++; $display("FAIL sel_boundary: tgt got %0d expected 2", theme_tgt); end
    lock = 1;
    press(1, 0);
    tests++; if (theme_tgt !== 4'd2) begin fails++; $display("FAIL lock_drop: tgt got %0d expected 2", theme_tgt); end
    lock = 0;
    waitn(10);
    tests++; if (theme_tgt !== 4'd2) begin fails++; $display("FAIL lock_no_late: tgt got %0d expected 2", theme_tgt); end
  endtask

  task automatic test_frame_race();
    sel(1);
    tests++; if (theme_pending !== 1'b1) begin fails++; $display("FAIL race_pending: got %0b expected 1", theme_pending); end
    sel_valid = 1; sel_idx = 4'd2; frame_start = 1;
    waitn(1);
    sel_valid = 0; frame_start = 0;
    tests++; if (theme !== 4'd1) begin fails++; $display("FAIL race_old_tgt: theme got %0d expected 1", theme); end
    tests++; if (theme_tgt !== 4'd2) begin fails++; $display("FAIL race_new_tgt: tgt got %0d expected 2", theme_tgt); end
    pulse_frame();
    tests++; if (theme !== 4'd2) begin fails++; $display("FAIL race_next_frame: theme got %0d expected 2", theme); end
  endtask

  task automatic test_rst_debounce();
    btn_next = 1;
    waitn(4);
    rst = 1; btn_next = 0;
    waitn(2);
    rst = 0;
    waitn(15);
    tests++; if (theme_tgt !== 4'd0) begin fails++; $display("FAIL rst_mid_debounce: tgt got %0d expected 0", theme_tgt); end
    tests++; if (theme !== 4'd0) begin fails++; $display("FAIL rst_theme: got %0d expected 0", theme); end
  endtask

  // Behavioural model: commit looks at the old target, then requests apply.
  function automatic void model_step(bit sv, int si, bit lk, bit ne, bit pe, bit fs);
    if (fs && m_tgt != m_theme) begin m_theme = m_tgt; m_chg = 1; end
    else m_chg = 0;
    if (!lk) begin
      if (sv && si < NT)  m_tgt = si;
      else if (ne && !pe) m_tgt = (m_tgt + 1) % NT;
      else if (pe && !ne) m_tgt = (m_tgt + NT - 1) % NT;
    end
  endfunction

  task automatic rcycle();
    @(posedge clk);
    cyc++;
    model_step(sel_valid, int'(sel_idx), lock, cyc == nxt_due, cyc == prv_due, frame_start);
    #1;
    tests++; if (theme !== 4'(m_theme)) begin fails++; $display("FAIL rand_theme cyc%0d: got %0d expected %0d", cyc, theme, m_theme); end
    tests++; if (theme_tgt !== 4'(m_tgt)) begin fails++; $display("FAIL rand_tgt cyc%0d: got %0d expected %0d", cyc, theme_tgt, m_tgt); end
    tests++; if (theme_chg !== 1'(m_chg)) begin fails++; $display("FAIL rand_chg cyc%0d: got %0b expected %0d", cyc, theme_chg, m_chg); end
    tests++; if (theme_pending !== (m_tgt != m_theme)) begin fails++; $display("FAIL rand_pending cyc%0d: got %0b expected %0b", cyc, theme_pending, m_tgt != m_theme); end
  endtask

  task automatic test_random();
    int k;
    do_reset();
    m_tgt = 0; m_theme = 0; m_chg = 0;
    cyc = 0; nxt_due = -1; prv_due = -1;
    for (int e = 0; e < 60; e++) begin
      case ($urandom_range(0, 3))
        0: begin
          sel_valid = 1; sel_idx = 4'($urandom_range(0, 7));
          lock = ($urandom_range(0, 3) == 0); frame_start = 1'($urandom_range(0, 1));
          rcycle();
          sel_valid = 0; lock = 0; frame_start = 0;
        end
        1: begin
          frame_start = 1; rcycle(); frame_start = 0;
        end
        default: begin
          lock = ($urandom_range(0, 3) == 0);
          k = $urandom_range(0, 2);
          btn_next = (k != 1); btn_prev = (k != 0);
          nxt_due = btn_next ? cyc + 7 : -1;
          prv_due = btn_prev ? cyc + 7 : -1;
          for (int j = 0; j < 20; j++) begin
            if (j == 10) begin btn_next = 0; btn_prev = 0; end
            frame_start = ($urandom_range(0, 4) == 0);
            sel_valid = ($urandom_range(0, 5) == 0);
            sel_idx = 4'($urandom_range(0, 4));
            rcycle();
          end
          frame_start = 0; sel_valid = 0; lock = 0;
          nxt_due = -1; prv_due = -1;
        end
      endcase
    end
  endtask

  initial begin
    rst = 1; btn_next = 0; btn_prev = 0; sel_valid = 0; sel_idx = '0;
    lock = 0; frame_start = 0;
    test_reset();
    test_next_commit();
    test_accumulate();
    test_bounce();
    test_sel();
    test_frame_race();
    test_rst_debounce();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
